// File: rtl/iob_axistream_serializer_pkg.sv
// Shared types and constants for the word-to-byte AXI-stream serializer.
// State encoding, packet-length counter width and word geometry helpers.
package iob_axistream_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    localparam int PKT_LEN_W = 16;

    // Bytes per input word.
    function automatic int calc_nb(input int data_w);
        return data_w / 8;
    endfunction

    // Width of the byte index / byte count fields (at least one bit).
    function automatic int calc_bw(input int data_w);
        return (data_w / 8 > 1) ? $clog2(data_w / 8) : 1;
    endfunction

endpackage

// File: rtl/iob_axistream_serializer_pktlen.sv
// Packet length counter: counts output handshakes and reports the total
// (modulo 2^16) with a one-cycle valid pulse on the handshake of the tlast byte.
module iob_axistream_serializer_pktlen
    import iob_axistream_serializer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_beat,
    input  logic                 i_last,
    output logic [PKT_LEN_W-1:0] o_pkt_len,
    output logic                 o_pkt_len_valid
);

    logic [PKT_LEN_W-1:0] r_count;
    logic [PKT_LEN_W-1:0] r_pkt_len;
    logic                 r_pkt_len_valid;
    logic [PKT_LEN_W-1:0] w_count_inc;

    assign w_count_inc = r_count + PKT_LEN_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count         <= '0;
            r_pkt_len       <= '0;
            r_pkt_len_valid <= 1'b0;
        end else begin
            r_pkt_len_valid <= 1'b0;
            if (i_beat) begin
                if (i_last) begin
                    r_pkt_len       <= w_count_inc;
                    r_pkt_len_valid <= 1'b1;
                    r_count         <= '0;
                end else begin
                    r_count <= w_count_inc;
                end
            end
        end
    end

    assign o_pkt_len       = r_pkt_len;
    assign o_pkt_len_valid = r_pkt_len_valid;

endmodule

// File: rtl/iob_axistream_serializer.sv
// Wide-word to byte-wide AXI-stream serializer, LSB first, partial last word.
// Optional packet length reporting under IOB_AXISTREAM_SERIALIZER_PKTLEN_EN.
module iob_axistream_serializer
    import iob_axistream_serializer_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int NB     = calc_nb(DATA_W),
    localparam int BW     = calc_bw(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic [BW-1:0]     s_tbytes,
    input  logic              s_tlast,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [7:0]        m_tdata,
    output logic              m_tlast,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              busy
`ifdef IOB_AXISTREAM_SERIALIZER_PKTLEN_EN
    ,
    output logic [PKT_LEN_W-1:0] pkt_len,
    output logic                 pkt_len_valid
`endif
);

    ser_state_e        r_state;
    logic [DATA_W-1:0] r_word;
    logic [BW-1:0]     r_idx;
    logic [BW-1:0]     r_lidx;
    logic              r_tlast;

    logic              w_shift;
    logic              w_at_last;
    logic              w_out_hs;
    logic              w_in_hs;
    logic [BW-1:0]     w_lidx_next;
    logic [7:0]        w_bytes [NB];

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_byte_lane
            assign w_bytes[gi] = r_word[8*gi +: 8];
        end
    endgenerate

    assign w_shift   = (r_state == SHIFT);
    assign w_at_last = w_shift && (r_idx == r_lidx);
    assign w_out_hs  = w_shift && m_tready;

    // Only combinational path: a word slot frees up as the last byte leaves.
    assign s_tready = !w_shift || (w_at_last && m_tready);
    assign w_in_hs  = s_tvalid && s_tready;

    always_comb begin
        w_lidx_next = BW'(NB - 1);
        if (s_tlast && (s_tbytes != '0)) begin
            w_lidx_next = s_tbytes - BW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_word  <= '0;
            r_idx   <= '0;
            r_lidx  <= '0;
            r_tlast <= 1'b0;
        end else if (w_in_hs) begin
            // Covers both the idle load and the bubble-free reload.
            r_state <= SHIFT;
            r_word  <= s_tdata;
            r_idx   <= '0;
            r_lidx  <= w_lidx_next;
            r_tlast <= s_tlast;
        end else if (w_out_hs) begin
            if (w_at_last) begin
                r_state <= IDLE;
            end else begin
                r_idx <= r_idx + BW'(1);
            end
        end
    end

    assign m_tvalid = w_shift;
    assign m_tdata  = w_shift ? w_bytes[r_idx] : 8'h00;
    assign m_tlast  = r_tlast && w_at_last;
    assign busy     = w_shift;

`ifdef IOB_AXISTREAM_SERIALIZER_PKTLEN_EN
    iob_axistream_serializer_pktlen u_pktlen (
        .clk             (clk),
        .rst             (rst),
        .i_beat          (w_out_hs),
        .i_last          (m_tlast),
        .o_pkt_len       (pkt_len),
        .o_pkt_len_valid (pkt_len_valid)
    );
`endif

endmodule

// File: tb/tb_iob_axistream_serializer.sv
// Scoreboard bench for iob_axistream_serializer: stimulus pushes expected
// bytes (and packet lengths when IOB_AXISTREAM_SERIALIZER_PKTLEN_EN is set).
module tb_iob_axistream_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_tdata;
    logic [1:0]  s_tbytes;
    logic        s_tlast;
    logic        s_tvalid;
    logic        s_tready;
    logic [7:0]  m_tdata;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic        busy;
`ifdef IOB_AXISTREAM_SERIALIZER_PKTLEN_EN
    logic [15:0] pkt_len;
    logic        pkt_len_valid;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] exp_q[$];
    int         pkt_q[$];

    always #5 clk = ~clk;

    iob_axistream_serializer #(.DATA_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (s_tdata),
        .s_tbytes (s_tbytes),
        .s_tlast  (s_tlast),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tlast  (m_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .busy     (busy)
`ifdef IOB_AXISTREAM_SERIALIZER_PKTLEN_EN
        ,
        .pkt_len       (pkt_len),
        .pkt_len_valid (pkt_len_valid)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_pkt(input int n);
`ifdef IOB_AXISTREAM_SERIALIZER_PKTLEN_EN
        pkt_q.push_back(n);
`else
        if (n < 0) $display("negative packet length %0d", n);
`endif
    endtask

    // Byte monitor: pops one expected byte per output handshake and checks
    // that a stalled byte stays put until it is taken.
    initial begin : byte_monitor
        logic       hold_pending;
        logic [8:0] hold_val;
        logic [8:0] exp;
        hold_pending = 1'b0;
        hold_val     = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_pending = 1'b0;
            end else begin
                if (hold_pending) begin
                    check("hold_valid", 32'(m_tvalid), 32'd1);
                    check("hold_byte", 32'({m_tlast, m_tdata}), 32'(hold_val));
                end
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got data 0x%0h last %0b, expected none", m_tdata, m_tlast);
                    end else begin
                        exp = exp_q.pop_front();
                        check("byte", 32'({m_tlast, m_tdata}), 32'(exp));
                        $display("byte 0x%02h last=%0b", m_tdata, m_tlast);
                    end
                end
                hold_pending = m_tvalid && !m_tready;
                hold_val     = {m_tlast, m_tdata};
            end
        end
    end

`ifdef IOB_AXISTREAM_SERIALIZER_PKTLEN_EN
    initial begin : pkt_monitor
        int exp_len;
        forever begin
            @(negedge clk);
            if (!rst && pkt_len_valid) begin
                if (pkt_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pkt_len: got %0d, expected no pulse", pkt_len);
                end else begin
                    exp_len = pkt_q.pop_front();
                    check("pkt_len", 32'(pkt_len), 32'(exp_len));
                    $display("pkt_len %0d", pkt_len);
                end
            end
        end
    end
`endif

    task automatic send_word(input logic [31:0] data, input logic last, input logic [1:0] nbytes);
        int n;
        n = (last && nbytes != 2'd0) ? int'(nbytes) : 4;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({last && (i == n - 1), data[8*i +: 8]});
        end
        s_tdata  = data;
        s_tlast  = last;
        s_tbytes = nbytes;
        s_tvalid = 1'b1;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (s_tready) break;
            if (t > 500) begin
                check("s_tready_timeout", 32'(s_tready), 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !m_tvalid) break;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({name, "_busy_low"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        logic       exp_rdy [10];
        logic       bp_pat  [16];
        rst      = 1'b1;
        s_tdata  = '0;
        s_tbytes = '0;
        s_tlast  = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b0;

        // Reset values
        @(negedge clk);
        check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_m_tdata", 32'(m_tdata), 32'd0);
        check("rst_m_tlast", 32'(m_tlast), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_s_tready", 32'(s_tready), 32'd1);
`ifdef IOB_AXISTREAM_SERIALIZER_PKTLEN_EN
        check("rst_pkt_len", 32'(pkt_len), 32'd0);
        check("rst_pkt_len_valid", 32'(pkt_len_valid), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst      = 1'b0;
        m_tready = 1'b1;
        @(posedge clk);
        #1;

        // Single full last word
        expect_pkt(4);
        send_word(32'h44332211, 1'b1, 2'd0);
        drain("full_word");

        // Partial last word: only two bytes
        expect_pkt(2);
        send_word(32'hAABBCCDD, 1'b1, 2'd2);
        drain("partial_word");

        // Back-to-back words with no bubble
        for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), 8'(i)});
        expect_pkt(8);
        exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        s_tdata  = 32'h03020100;
        s_tlast  = 1'b0;
        s_tbytes = 2'd1;
        s_tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("b2b_s_tready_%0d", i), 32'(s_tready), 32'(exp_rdy[i]));
            if (i >= 1 && i <= 8) check($sformatf("b2b_no_gap_%0d", i), 32'(m_tvalid), 32'd1);
            @(posedge clk);
            #1;
            if (i == 0) begin
                s_tdata  = 32'h07060504;
                s_tlast  = 1'b1;
                s_tbytes = 2'd0;
            end
            if (i == 4) s_tvalid = 1'b0;
        end
        drain("back_to_back");

        // Backpressure, including a long stall
        bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        expect_pkt(4);
        fork
            send_word(32'h0D0C0B0A, 1'b1, 2'd0);
            begin
                for (int i = 0; i < 16; i++) begin
                    m_tready = bp_pat[i];
                    @(negedge clk);
                    if (m_tvalid && (!m_tlast || !m_tready))
                        check($sformatf("bp_s_tready_%0d", i), 32'(s_tready), 32'd0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        m_tready = 1'b1;
        drain("backpressure");

        // Reset in the middle of a packet
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h22});
        s_tdata  = 32'h44332211;
        s_tlast  = 1'b1;
        s_tbytes = 2'd0;
        s_tvalid = 1'b1;
        @(negedge clk);
        check("mid_rst_accept", 32'(s_tready), 32'd1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("mid_rst_m_tlast", 32'(m_tlast), 32'd0);
        check("mid_rst_s_tready", 32'(s_tready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("post_rst_s_tready", 32'(s_tready), 32'd1);
        check("post_rst_queue", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        expect_pkt(1);
        send_word(32'h000000EE, 1'b1, 2'd1);
        drain("after_reset");

        // Multi-word packet: 4 + 4 + 3 bytes, then a new one-byte packet
        expect_pkt(11);
        send_word(32'h13121110, 1'b0, 2'd0);
        send_word(32'h17161514, 1'b0, 2'd3);
        send_word(32'h1B1A1918, 1'b1, 2'd3);
        drain("pkt_11");
        expect_pkt(1);
        send_word(32'h0000005A, 1'b1, 2'd1);
        drain("pkt_1");

        repeat (4) @(posedge clk);
        check("pkt_q_empty", 32'(pkt_q.size()), 32'd0);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/iob_axistream_serializer.md
Name: iob_axistream_serializer

Overview:
- Upstream feeder for the AXI-stream-to-CPU FIFO block.
- Takes wide words (default 32 bit) from a producer, e.g. a DMA/CPU-side register or accelerator, and emits a byte-wide AXI stream (tdata 8 bit, tvalid, tready, tlast).
- Byte order LSB first; a final partial word is supported via a byte-count field.
- Sustains 1 byte/cycle, including back-to-back words with no bubble.

Parameters:
DATA_W, 32, input word width; multiple of 8, at least 16
NB, DATA_W/8, derived (localparam): bytes per word
BW, $clog2(NB), derived (localparam): width of byte index and byte count

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
s_tdata  input  DATA_W  input word
s_tbytes  input  BW  valid bytes in a last word, 0 = NB; ignored unless s_tlast=1
s_tlast  input  1  word ends the packet
s_tvalid  input  1  input word valid
s_tready  output  1  input word accepted when s_tvalid & s_tready
m_tdata  output  8  output byte
m_tlast  output  1  final byte of packet
m_tvalid  output  1  output byte valid
m_tready  input  1  downstream ready (connects to ~fifo_full of the consumer)
busy  output  1  word held, not yet fully emitted

Behaviour:
- Reset values: all outputs 0 except s_tready.
  - s_tready is 1 once idle, i.e. immediately after reset.
  - Internal registers cleared: word holding register, byte index idx, last-index lidx, tlast flag.
- Reset mid-packet: the held word and its remaining bytes are discarded and no tlast is emitted. The consumer must tolerate the truncation.
- States:
  - IDLE:
    - s_tready=1, m_tvalid=0.
    - On s_tvalid: latch s_tdata, set idx=0, then go to SHIFT.
    - lidx = (s_tlast ? (s_tbytes==0 ? NB-1 : s_tbytes-1) : NB-1).
  - SHIFT:
    - Outputs: m_tvalid=1; m_tdata = word[8*idx +: 8]; m_tlast = tlast_flag & (idx==lidx).
    - On m_tready with idx<lidx: idx increments.
    - On m_tready with idx==lidx:
      - s_tready=1 combinationally (s_tready = IDLE | (SHIFT & idx==lidx & m_tready)).
      - If s_tvalid: load the next word in the same cycle and remain in SHIFT with idx=0, giving no bubble.
      - Otherwise go to IDLE.
- Latency: byte 0 is valid the cycle after the input handshake. Output is registered state; the only combinational path is m_tready -> s_tready.
- AXI rules:
  - m_tdata and m_tlast are stable while m_tvalid & ~m_tready.
  - m_tvalid never drops without a handshake, except on rst.
- Boundary conditions:
  - s_tbytes=1 on a last word: emit a single byte with m_tlast=1.
  - s_tlast=0: s_tbytes is ignored and all NB bytes are emitted.
  - A packet of one word is valid.
  - m_tready held low indefinitely: hold the current byte; s_tready stays 0.
- busy = (state==SHIFT).

Optional Feature:
IOB_AXISTREAM_SERIALIZER_PKTLEN_EN
- Enabled: adds the following ports.
  - pkt_len, output, 16 bit.
  - pkt_len_valid, output, 1 bit.
- Enabled, behaviour:
  - An internal 16-bit counter increments on every output handshake.
  - On the handshake of a byte with m_tlast=1: pkt_len <= count+1, pkt_len_valid pulses 1 cycle, and the counter clears.
  - The counter wraps modulo 2^16.
  - Reset: pkt_len=0, pkt_len_valid=0.
- Disabled: the ports and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/header iob_axistream_serializer_pkg:
  - State encoding localparams: IDLE=1'b0, SHIFT=1'b1.
  - Helper for NB/BW.
  - Packet-length width constant (16).
- Sub-modules:
  - The word/index datapath stays inline.
  - One natural sub-module: iob_axistream_serializer_pktlen (the optional counter), instantiated only under the macro.

Test Plan:
- Single full last word: s_tdata=0x44332211, s_tlast=1, s_tbytes=0, m_tready=1 -> m_tdata 0x11,0x22,0x33,0x44 on 4 consecutive cycles; m_tlast only on 0x44; busy low afterwards.
- Partial last word: 0xAABBCCDD, s_tlast=1, s_tbytes=2 -> bytes 0xDD,0xCC; m_tlast on 0xCC; 0xBB/0xAA never emitted.
- Back-to-back: words 0x03020100 (tlast=0) then 0x07060504 (tlast=1, tbytes=0) held valid, m_tready=1 -> 8 bytes 0x00..0x07 on 8 consecutive cycles, no gap; s_tready high exactly on the cycles of byte 0x03 and before byte 0x00.
- Backpressure: m_tready toggled 1,0,0,1,... -> m_tdata/m_tlast stable during low cycles; no byte lost or duplicated; s_tready=0 while bytes remain.
- Reset mid-packet: assert rst after the second byte of 0x44332211 -> m_tvalid=0 and s_tready=1 after release; the next packet 0x000000EE (tbytes=1) emits only 0xEE with m_tlast.
- PKTLEN_EN: packet of 2 full words + 3-byte last word -> pkt_len=11 with a 1-cycle pkt_len_valid on the tlast handshake; the next packet counts from 0.
